// File: rtl/game_pkg.sv
// Shared definitions between the move input parser and the game controller.
package game_pkg;

    localparam int COORD_W   = 4;
    localparam int BOARD_DIM = 10;

    // Parser FSM states
    typedef enum logic [1:0] {
        COLLECT_Y = 2'd0,
        COLLECT_X = 2'd1,
        ARMED     = 2'd2,
        OFFER     = 2'd3
    } state_t;

    // Board cell encoding owned by the controller
    typedef enum logic [1:0] {
        CELL_EMPTY    = 2'b00,
        CELL_TRIANGLE = 2'b01,
        CELL_CIRCLE   = 2'b10
    } cell_t;

endpackage

// File: rtl/move_input_parser_if.sv
// Move handshake between the input parser (master) and the game controller (slave).
interface move_input_parser_if;
    import game_pkg::*;

    logic               move_valid;
    logic               move_ready;
    logic [COORD_W-1:0] move_y;
    logic [COORD_W-1:0] move_x;

    modport master (output move_valid, move_y, move_x, input move_ready);
    modport slave  (input move_valid, move_y, move_x, output move_ready);

endinterface

// File: rtl/button_debounce.sv
// One button: 2-flop synchroniser, polarity normalisation, debounce counter
// and a single-cycle pulse on each debounced press.
module button_debounce #(
    parameter int DB_CYCLES          = 500000,
    parameter bit BUTTON_ACTIVE_HIGH = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic press
);
    localparam int            CW       = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
    localparam logic          IDLE     = BUTTON_ACTIVE_HIGH ? 1'b0 : 1'b1;

    logic [1:0]    sync;
    logic          level;
    logic          level_db;
    logic [CW-1:0] cnt;
    logic [1:0]    fill;
    logic          armed;

    // Synchroniser resets to the idle level so reset itself looks like "released"
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= {IDLE, IDLE};
        else        sync <= {sync[0], raw};
    end

    assign level = BUTTON_ACTIVE_HIGH ? sync[1] : ~sync[1];

    // Debounced level follows the input only after DB_CYCLES stable samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            level_db <= 1'b0;
            press    <= 1'b0;
        end else begin
            press <= 1'b0;
            if (level == level_db) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt      <= '0;
                level_db <= level;
                press    <= level & armed;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // A button held through reset must be seen released before it can press
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill  <= 2'b00;
            armed <= 1'b0;
        end else begin
            fill <= {fill[0], 1'b1};
            if (fill[1] && !level) armed <= 1'b1;
        end
    end

endmodule

// File: rtl/move_input_parser.sv
// Collects a bit-serial row/column from debounced buttons, range-checks it on
// an activity press and offers it as one move over a valid/ready handshake.
module move_input_parser
    import game_pkg::*;
#(
    parameter int DB_CYCLES          = 500000,
    parameter bit BUTTON_ACTIVE_HIGH = 1'b1,
    parameter int COORD_MAX          = 9
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       logic_0_button,
    input  logic                       logic_1_button,
    input  logic                       activity_button,
    move_input_parser_if.master        move,
    output logic [3:0]                 bit_count,
    output logic                       entry_error
);
    localparam logic [COORD_W-1:0] MAX = COORD_W'(COORD_MAX);

    logic [2:0] raw;
    logic [2:0] press;
    logic       p0, p1, pa, bit_ev;

    state_t             state, state_n;
    logic [COORD_W-1:0] y, y_n, x, x_n;
    logic [3:0]         cnt, cnt_n;
    logic               err_n;

    assign raw = {activity_button, logic_1_button, logic_0_button};

    for (genvar i = 0; i < 3; i++) begin : g_db
        button_debounce #(
            .DB_CYCLES         (DB_CYCLES),
            .BUTTON_ACTIVE_HIGH(BUTTON_ACTIVE_HIGH)
        ) u_db (
            .clk  (clk),
            .rst_n(rst_n),
            .raw  (raw[i]),
            .press(press[i])
        );
    end

    assign p0 = press[0];
    assign p1 = press[1];
    assign pa = press[2];
    // Simultaneous 0 and 1 presses cancel each other out
    assign bit_ev = p0 ^ p1;

    // Next-state: bit collection, abort, range check and handshake
    always_comb begin
        state_n = state;
        y_n     = y;
        x_n     = x;
        cnt_n   = cnt;
        err_n   = 1'b0;
        case (state)
            COLLECT_Y: begin
                if (pa) begin
                    y_n = '0; x_n = '0; cnt_n = '0;
                end else if (bit_ev) begin
                    y_n[cnt[1:0]] = p1;
                    cnt_n         = cnt + 4'd1;
                    if (cnt == 4'd3) state_n = COLLECT_X;
                end
            end
            COLLECT_X: begin
                if (pa) begin
                    y_n = '0; x_n = '0; cnt_n = '0;
                    state_n = COLLECT_Y;
                end else if (bit_ev) begin
                    x_n[cnt[1:0]] = p1;
                    cnt_n         = cnt + 4'd1;
                    if (cnt == 4'd7) state_n = ARMED;
                end
            end
            ARMED: begin
                if (pa) begin
                    if (y > MAX || x > MAX) begin
                        err_n = 1'b1;
                        y_n = '0; x_n = '0; cnt_n = '0;
                        state_n = COLLECT_Y;
                    end else begin
                        state_n = OFFER;
                    end
                end
            end
            OFFER: begin
                if (move.move_ready) begin
                    y_n = '0; x_n = '0; cnt_n = '0;
                    state_n = COLLECT_Y;
                end
            end
            default: state_n = COLLECT_Y;
        endcase
    end

    // State and coordinate registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= COLLECT_Y;
            y           <= '0;
            x           <= '0;
            cnt         <= '0;
            entry_error <= 1'b0;
        end else begin
            state       <= state_n;
            y           <= y_n;
            x           <= x_n;
            cnt         <= cnt_n;
            entry_error <= err_n;
        end
    end

    assign move.move_valid = (state == OFFER);
    assign move.move_y     = y;
    assign move.move_x     = x;
    assign bit_count       = cnt;

endmodule

// File: tb/tb_move_input_parser.sv
// Randomised bench for move_input_parser with a scoreboard of expected moves/errors.
module tb_move_input_parser;
    import game_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       l0 = 1'b0, l1 = 1'b0, la = 1'b0;
    logic [3:0] bit_count;
    logic       entry_error;

    move_input_parser_if mif();

    move_input_parser #(
        .DB_CYCLES(4), .BUTTON_ACTIVE_HIGH(1'b1), .COORD_MAX(9)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .logic_0_button (l0),
        .logic_1_button (l1),
        .activity_button(la),
        .move           (mif),
        .bit_count      (bit_count),
        .entry_error    (entry_error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit         is_err;
        logic [3:0] y;
        logic [3:0] x;
    } exp_t;

    exp_t exp_q[$];
    int   bits[$];        // entered bits, in entry order
    bit   model_offer;    // a move is pending with ready low
    exp_t mon_e;
    bit   after_xfer;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    function automatic int model_count();
        return model_offer ? 8 : bits.size();
    endfunction

    // Reference: what a simultaneous set of presses means for the entry
    function automatic void model_apply(input bit b0, input bit b1, input bit ba);
        exp_t e;
        int   yv, xv;
        if (model_offer) return;
        if (ba) begin
            if (bits.size() == 8) begin
                yv = 0; xv = 0;
                for (int i = 0; i < 4; i++) begin
                    yv += bits[i] * (1 << i);
                    xv += bits[i+4] * (1 << i);
                end
                e.is_err = (yv > 9) || (xv > 9);
                e.y = 4'(yv);
                e.x = 4'(xv);
                exp_q.push_back(e);
                if (!e.is_err && !mif.move_ready) model_offer = 1'b1;
            end
            if (!model_offer) bits.delete();
        end else if (b0 != b1 && bits.size() < 8) begin
            bits.push_back(b1 ? 1 : 0);
        end
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input bit b0, input bit b1, input bit ba);
        model_apply(b0, b1, ba);
        l0 = b0; l1 = b1; la = ba;
        cyc(8);
        l0 = 1'b0; l1 = 1'b0; la = 1'b0;
        cyc(8);
        check("bit_count", int'(bit_count), model_count());
    endtask

    task automatic enter(input logic [3:0] y, input logic [3:0] x);
        for (int i = 0; i < 4; i++) press(!y[i], y[i], 1'b0);
        for (int i = 0; i < 4; i++) press(!x[i], x[i], 1'b0);
    endtask

    // Monitor: every transfer or error pulse consumes one expected item
    always @(negedge clk) begin
        if (rst_n) begin
            if (after_xfer) begin
                check("valid_drop", int'(mif.move_valid), 0);
                check("count_after_xfer", int'(bit_count), 0);
            end
            after_xfer = mif.move_valid && mif.move_ready;
            if (after_xfer) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_move: got y=%0d x=%0d expected none", mif.move_y, mif.move_x);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("move_kind", 0, int'(mon_e.is_err));
                    check("move_y", int'(mif.move_y), int'(mon_e.y));
                    check("move_x", int'(mif.move_x), int'(mon_e.x));
                end
            end
            if (entry_error) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_error: got entry_error=1 expected none");
                end else begin
                    mon_e = exp_q.pop_front();
                    check("error_kind", 1, int'(mon_e.is_err));
                end
            end
        end else begin
            after_xfer = 1'b0;
        end
    end

    initial begin
        model_offer = 1'b0;
        after_xfer  = 1'b0;
        mif.move_ready = 1'b1;
        #12;
        check("rst_valid", int'(mif.move_valid), 0);
        check("rst_y", int'(mif.move_y), 0);
        check("rst_x", int'(mif.move_x), 0);
        check("rst_count", int'(bit_count), 0);
        check("rst_err", int'(entry_error), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        cyc(4);

        // Basic move y=3 x=5
        enter(4'd3, 4'd5);
        press(1'b0, 1'b0, 1'b1);
        check("drained_basic", exp_q.size(), 0);

        // Out of range row, then boundary values
        enter(4'd10, 4'd0);
        press(1'b0, 1'b0, 1'b1);
        check("drained_err", exp_q.size(), 0);
        enter(4'd9, 4'd9);
        press(1'b0, 1'b0, 1'b1);
        enter(4'd9, 4'd10);
        press(1'b0, 1'b0, 1'b1);
        check("drained_bound", exp_q.size(), 0);

        // Chatter on logic_1 must count exactly once
        for (int k = 0; k < 6; k++) begin
            l1 = (k % 2 == 0);
            cyc(2);
        end
        l1 = 1'b1; cyc(10);
        l1 = 1'b0; cyc(10);
        model_apply(1'b0, 1'b1, 1'b0);
        check("chatter_count", int'(bit_count), model_count());
        press(1'b0, 1'b0, 1'b1);

        // Abort after three bits
        press(1'b0, 1'b1, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b0, 1'b1);

        // Back-pressure: offer held while buttons toggle
        mif.move_ready = 1'b0;
        enter(4'd4, 4'd7);
        press(1'b0, 1'b0, 1'b1);
        check("valid_held", int'(mif.move_valid), 1);
        for (int k = 0; k < 20; k++) begin
            l0 = 1'($urandom); l1 = 1'($urandom); la = 1'($urandom);
            cyc(1);
            check("hold_valid", int'(mif.move_valid), 1);
            check("hold_y", int'(mif.move_y), 4);
            check("hold_x", int'(mif.move_x), 7);
            check("hold_count", int'(bit_count), 8);
        end
        l0 = 1'b0; l1 = 1'b0; la = 1'b0;
        cyc(10);
        check("valid_still", int'(mif.move_valid), 1);
        mif.move_ready = 1'b1;
        cyc(3);
        model_offer = 1'b0;
        bits.delete();
        check("bp_count", int'(bit_count), 0);
        check("drained_bp", exp_q.size(), 0);

        // Reset during an offer with a button held
        mif.move_ready = 1'b0;
        enter(4'd2, 4'd3);
        press(1'b0, 1'b0, 1'b1);
        l1 = 1'b1;
        cyc(2);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", int'(mif.move_valid), 0);
        check("mid_rst_y", int'(mif.move_y), 0);
        check("mid_rst_x", int'(mif.move_x), 0);
        check("mid_rst_count", int'(bit_count), 0);
        check("mid_rst_err", int'(entry_error), 0);
        exp_q.delete();
        bits.delete();
        model_offer = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        cyc(20);
        check("held_no_press", int'(bit_count), 0);
        l1 = 1'b0;
        cyc(10);
        mif.move_ready = 1'b1;
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b0, 1'b1);

        // Random presses, including simultaneous combinations
        for (int n = 0; n < 150; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 40)      press(1'b1, 1'b0, 1'b0);
            else if (r < 80) press(1'b0, 1'b1, 1'b0);
            else if (r < 86) press(1'b1, 1'b1, 1'b0);
            else if (r < 90) press(1'b0, 1'b1, 1'b1);
            else             press(1'b0, 1'b0, 1'b1);
        end

        cyc(10);
        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
